// File: rtl/sd_xfr_pkg.sv
// Shared codes, token constants and state encoding for the SD multi-block
// transfer sequencer.
package sd_xfr_pkg;

  localparam logic [1:0] SD_DAT_NONE  = 2'b00;
  localparam logic [1:0] SD_DAT_WRITE = 2'b01;
  localparam logic [1:0] SD_DAT_READ  = 2'b10;
  localparam logic [1:0] SD_DAT_ABORT = 2'b11;

  localparam logic [2:0] TOK_OK  = 3'b010;
  localparam logic [2:0] TOK_CRC = 3'b101;

  localparam logic [1:0] FIFO_DATA_ADR = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_WR_TOKEN,
    ST_WR_BUSY,
    ST_RD_DATA,
    ST_BLK_END,
    ST_GAP,
    ST_ABORT,
    ST_DONE
  } xfr_state_e;

endpackage

// File: rtl/sd_xfr_timer.sv
// Per-block phase timer: loads TIMEOUT, counts down while enabled and flags
// the decrement that reaches zero.
module sd_xfr_timer #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CW'(TIMEOUT);
    end else if (dec_i && count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = dec_i && (count_q == CW'(1));

endmodule

// File: rtl/sd_data_xfer_ctrl.sv
// Multi-block transfer sequencer driving sd_data_phy start/FIFO controls and
// tracking write tokens, card busy and read byte counts per block.
module sd_data_xfer_ctrl
  import sd_xfr_pkg::*;
#(
  parameter int unsigned BLK_BYTES  = 512,
  parameter int unsigned BLK_CNT_W  = 16,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_xfr_i,
  input  logic                 dir_i,
  input  logic [BLK_CNT_W-1:0] blk_num_i,
  input  logic                 abort_i,
  input  logic                 tx_fifo_empty_i,
  input  logic                 rx_fifo_full_i,
  input  logic                 dat0_i,
  input  logic                 phy_we_i,
  input  logic [1:0]           phy_adr_i,
  input  logic [7:0]           phy_dat_i,
  output logic [1:0]           start_dat_o,
  output logic                 fifo_acces_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           status_o,
  output logic [BLK_CNT_W-1:0] blks_done_o
);

  localparam int unsigned BW = $clog2(BLK_BYTES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  xfr_state_e           state_q, state_d;
  logic                 dir_q, dir_d;
  logic [BLK_CNT_W-1:0] blk_num_q, blk_num_d;
  logic [BLK_CNT_W-1:0] blks_done_q, blks_done_d;
  logic [2:0]           status_q, status_d;
  logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                 dat0_hi_q, dat0_hi_d;
  logic                 fifo_acces_q, fifo_acces_d;

  logic       strobe;
  logic [2:0] tok;
  logic       tmr_load, tmr_dec, tmr_expired;
  logic       unused_dat;

  assign strobe     = phy_we_i && (phy_adr_i == FIFO_DATA_ADR);
  assign tok        = {phy_dat_i[1], phy_dat_i[2], phy_dat_i[3]};
  assign unused_dat = ^{phy_dat_i[7:4], phy_dat_i[0]};

  assign tmr_load = (state_q == ST_START);
  assign tmr_dec  = state_q inside {ST_WR_TOKEN, ST_WR_BUSY, ST_RD_DATA};

  sd_xfr_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (sd_clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .dec_i     (tmr_dec),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dir_q        <= 1'b0;
      blk_num_q    <= '0;
      blks_done_q  <= '0;
      status_q     <= '0;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      dat0_hi_q    <= 1'b0;
      fifo_acces_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      blk_num_q    <= blk_num_d;
      blks_done_q  <= blks_done_d;
      status_q     <= status_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dat0_hi_q    <= dat0_hi_d;
      fifo_acces_q <= fifo_acces_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    blk_num_d    = blk_num_q;
    blks_done_d  = blks_done_q;
    status_d     = status_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    dat0_hi_d    = 1'b0;
    fifo_acces_d = (state_q == ST_RD_DATA) && !rx_fifo_full_i;

    case (state_q)
      ST_IDLE: begin
        if (start_xfr_i) begin
          dir_d       = dir_i;
          blk_num_d   = blk_num_i;
          status_d    = '0;
          blks_done_d = '0;
          state_d     = ST_ARM;
        end
      end
      ST_ARM: begin
        if (dir_q || !tx_fifo_empty_i) state_d = ST_START;
      end
      ST_START: begin
        byte_cnt_d = '0;
        state_d    = dir_q ? ST_RD_DATA : ST_WR_TOKEN;
      end
      ST_WR_TOKEN: begin
        if (strobe) begin
          if (tok == TOK_OK) begin
            state_d = ST_WR_BUSY;
          end else if (tok == TOK_CRC) begin
            status_d[1] = 1'b1;
            state_d     = ST_ABORT;
          end else begin
            status_d[0] = 1'b1;
            state_d     = ST_ABORT;
          end
        end
      end
      ST_WR_BUSY: begin
        dat0_hi_d = dat0_i;
        if (dat0_i && dat0_hi_q) state_d = ST_BLK_END;
      end
      ST_RD_DATA: begin
        if (strobe) begin
          if (byte_cnt_q == BW'(BLK_BYTES - 1)) begin
            state_d = ST_BLK_END;
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
      end
      ST_BLK_END: begin
        blks_done_d = blks_done_q + BLK_CNT_W'(1);
        gap_cnt_d   = '0;
        state_d     = (blks_done_q == blk_num_q) ? ST_DONE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = ST_ARM;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      ST_ABORT: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Timeout outranks a simultaneous abort_i or phase event; either one
    // discards any status the phase logic above tried to record.
    if (state_q inside {ST_ARM, ST_START, ST_WR_TOKEN, ST_WR_BUSY,
                        ST_RD_DATA, ST_BLK_END, ST_GAP}) begin
      if (tmr_expired) begin
        status_d    = status_q;
        status_d[2] = 1'b1;
        state_d     = ST_ABORT;
      end else if (abort_i) begin
        status_d = status_q;
        state_d  = ST_ABORT;
      end
    end
  end

  always_comb begin
    start_dat_o = SD_DAT_NONE;
    case (state_q)
      ST_START: start_dat_o = dir_q ? SD_DAT_READ : SD_DAT_WRITE;
      ST_ABORT: start_dat_o = SD_DAT_ABORT;
      default:  start_dat_o = SD_DAT_NONE;
    endcase
    busy_o       = !(state_q inside {ST_IDLE, ST_DONE});
    done_o       = (state_q == ST_DONE);
    status_o     = status_q;
    blks_done_o  = blks_done_q;
    fifo_acces_o = fifo_acces_q;
  end

endmodule

// File: tb/tb_sd_data_xfer_ctrl.sv
// Directed self-checking bench for sd_data_xfer_ctrl with a short timeout so
// the expiry path is reachable.
module tb_sd_data_xfer_ctrl;

  localparam int unsigned BLK  = 512;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned GAP  = 8;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic        start_xfr_i;
  logic        dir_i;
  logic [15:0] blk_num_i;
  logic        abort_i;
  logic        tx_fifo_empty_i;
  logic        rx_fifo_full_i;
  logic        dat0_i;
  logic        phy_we_i;
  logic [1:0]  phy_adr_i;
  logic [7:0]  phy_dat_i;
  logic [1:0]  start_dat_o;
  logic        fifo_acces_o;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  status_o;
  logic [15:0] blks_done_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned cyc = 0, n_wr = 0, n_rd = 0, n_ab = 0, n_held = 0;
  int unsigned last_rd = 0, rd_space = 0;
  logic        prev_nz = 1'b0;

  sd_data_xfer_ctrl #(
    .BLK_BYTES  (BLK),
    .BLK_CNT_W  (16),
    .TIMEOUT    (TMO),
    .GAP_CYCLES (GAP)
  ) dut (
    .sd_clk          (sd_clk),
    .rst             (rst),
    .start_xfr_i     (start_xfr_i),
    .dir_i           (dir_i),
    .blk_num_i       (blk_num_i),
    .abort_i         (abort_i),
    .tx_fifo_empty_i (tx_fifo_empty_i),
    .rx_fifo_full_i  (rx_fifo_full_i),
    .dat0_i          (dat0_i),
    .phy_we_i        (phy_we_i),
    .phy_adr_i       (phy_adr_i),
    .phy_dat_i       (phy_dat_i),
    .start_dat_o     (start_dat_o),
    .fifo_acces_o    (fifo_acces_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .status_o        (status_o),
    .blks_done_o     (blks_done_o)
  );

  always #5 sd_clk = ~sd_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge sd_clk) begin
    cyc = cyc + 1;
    if (start_dat_o != 2'b00 && prev_nz) n_held = n_held + 1;
    prev_nz = (start_dat_o != 2'b00);
    if (start_dat_o == 2'b01) n_wr = n_wr + 1;
    if (start_dat_o == 2'b11) n_ab = n_ab + 1;
    if (start_dat_o == 2'b10) begin
      n_rd     = n_rd + 1;
      rd_space = cyc - last_rd;
      last_rd  = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic begin_xfr(input logic dir, input logic [15:0] blk);
    start_xfr_i = 1'b1;
    dir_i       = dir;
    blk_num_i   = blk;
    tick();
    start_xfr_i = 1'b0;
  endtask

  task automatic wait_code(input string tag, input logic [1:0] code);
    int unsigned n = 0;
    while (start_dat_o !== code && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_code"}, 32'(start_dat_o), 32'(code));
  endtask

  task automatic strobes(input int unsigned n, input logic [7:0] d);
    phy_we_i  = 1'b1;
    phy_adr_i = 2'd3;
    phy_dat_i = d;
    repeat (n) tick();
    phy_we_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start_dat"}, 32'(start_dat_o), 32'd0);
    check({tag, "_fifo"},      32'(fifo_acces_o), 32'd0);
    check({tag, "_busy"},      32'(busy_o), 32'd0);
    check({tag, "_done"},      32'(done_o), 32'd0);
    check({tag, "_status"},    32'(status_o), 32'd0);
    check({tag, "_blks"},      32'(blks_done_o), 32'd0);
  endtask

  logic [7:0] tok_byte [2];
  logic [2:0] tok_stat [2];
  int unsigned s_wr, s_rd, s_ab, n;

  initial begin
    rst = 1'b1; start_xfr_i = 1'b0; dir_i = 1'b0; blk_num_i = '0; abort_i = 1'b0;
    tx_fifo_empty_i = 1'b0; rx_fifo_full_i = 1'b0; dat0_i = 1'b1;
    phy_we_i = 1'b0; phy_adr_i = 2'd0; phy_dat_i = 8'h00;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single-block write with a one-cycle dat0 blip inside the busy period
    s_wr = n_wr; s_ab = n_ab;
    begin_xfr(1'b0, 16'd0);
    check("wr_busy_arm", 32'(busy_o), 32'd1);
    wait_code("wr", 2'b01);
    tick();
    dat0_i = 1'b0;
    strobes(1, 8'h14);
    repeat (10) tick();
    dat0_i = 1'b1; tick(); dat0_i = 1'b0;
    repeat (10) tick();
    check("wr_blip_busy", 32'(busy_o), 32'd1);
    dat0_i = 1'b1;
    tick(); check("wr_done_t1", 32'(done_o), 32'd0);
    tick(); check("wr_done_t2", 32'(done_o), 32'd0);
    tick(); check("wr_done_t3", 32'(done_o), 32'd1);
    check("wr_status", 32'(status_o), 32'd0);
    check("wr_blks", 32'(blks_done_o), 32'd1);
    check("wr_busy_done", 32'(busy_o), 32'd0);
    tick();
    check("wr_pulses", n_wr - s_wr, 32'd1);
    check("wr_no_abort", n_ab - s_ab, 32'd0);

    // Three-block read
    s_rd = n_rd; s_ab = n_ab;
    begin_xfr(1'b1, 16'd2);
    for (int b = 0; b < 3; b++) begin
      wait_code("rd", 2'b10);
      tick();
      strobes(BLK, 8'hA5);
      check("rd_blks_mid", 32'(blks_done_o), 32'(b));
    end
    tick();
    check("rd_done", 32'(done_o), 32'd1);
    check("rd_blks", 32'(blks_done_o), 32'd3);
    check("rd_status", 32'(status_o), 32'd0);
    check("rd_pulses", n_rd - s_rd, 32'd3);
    check("rd_no_abort", n_ab - s_ab, 32'd0);
    check("rd_spacing", rd_space, 32'(BLK + GAP + 3));
    tick();

    // Token errors: CRC status and any other pattern
    tok_byte[0] = 8'h1A; tok_stat[0] = 3'b010;
    tok_byte[1] = 8'h00; tok_stat[1] = 3'b001;
    for (int i = 0; i < 2; i++) begin
      s_ab = n_ab;
      begin_xfr(1'b0, 16'd0);
      wait_code("tok", 2'b01);
      tick();
      strobes(1, tok_byte[i]);
      check("tok_abort_code", 32'(start_dat_o), 32'd3);
      tick();
      check("tok_done", 32'(done_o), 32'd1);
      check("tok_status", 32'(status_o), 32'(tok_stat[i]));
      check("tok_busy", 32'(busy_o), 32'd0);
      check("tok_blks", 32'(blks_done_o), 32'd0);
      tick();
      check("tok_abort_count", n_ab - s_ab, 32'd1);
    end

    // Read timeout, plus fifo_acces latency at RD_DATA entry
    begin_xfr(1'b1, 16'd0);
    wait_code("tmo", 2'b10);
    tick(); check("tmo_fifo_lat0", 32'(fifo_acces_o), 32'd0);
    tick(); check("tmo_fifo_lat1", 32'(fifo_acces_o), 32'd1);
    n = 2;
    while (start_dat_o !== 2'b11 && n < TMO + 100) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, 32'(TMO + 1));
    tick();
    check("tmo_done", 32'(done_o), 32'd1);
    check("tmo_status", 32'(status_o), 32'd4);
    tick();

    // rx FIFO full stall mid-read
    begin_xfr(1'b1, 16'd0);
    wait_code("rf", 2'b10);
    tick();
    strobes(200, 8'h3C);
    rx_fifo_full_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rf_stall_fifo", 32'(fifo_acces_o), 32'd0);
    end
    rx_fifo_full_i = 1'b0;
    tick();
    check("rf_resume_fifo", 32'(fifo_acces_o), 32'd1);
    strobes(311, 8'h3C);
    check("rf_busy_511", 32'(busy_o), 32'd1);
    strobes(1, 8'h3C);
    check("rf_done_512", 32'(done_o), 32'd0);
    tick();
    check("rf_done", 32'(done_o), 32'd1);
    check("rf_status", 32'(status_o), 32'd0);
    check("rf_blks", 32'(blks_done_o), 32'd1);
    tick();

    // abort_i during the inter-block gap
    s_ab = n_ab;
    begin_xfr(1'b1, 16'd1);
    wait_code("gab", 2'b10);
    tick();
    strobes(BLK, 8'h55);
    tick(); tick();
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    check("gab_abort_code", 32'(start_dat_o), 32'd3);
    tick();
    check("gab_done", 32'(done_o), 32'd1);
    check("gab_status", 32'(status_o), 32'd0);
    check("gab_blks", 32'(blks_done_o), 32'd1);
    check("gab_abort_count", n_ab - s_ab, 32'd1);
    tick();

    // start_xfr_i while busy (parked in ARM on empty tx FIFO) is ignored
    tx_fifo_empty_i = 1'b1;
    begin_xfr(1'b0, 16'd0);
    repeat (3) tick();
    check("arm_wait_busy", 32'(busy_o), 32'd1);
    check("arm_wait_code", 32'(start_dat_o), 32'd0);
    begin_xfr(1'b1, 16'd5);
    tx_fifo_empty_i = 1'b0;
    wait_code("ign", 2'b01);
    tick();
    dat0_i = 1'b1;
    strobes(1, 8'h14);
    tick(); tick(); tick();
    check("ign_done", 32'(done_o), 32'd1);
    check("ign_blks", 32'(blks_done_o), 32'd1);
    check("ign_status", 32'(status_o), 32'd0);
    tick();

    // abort_i in IDLE has no effect
    abort_i = 1'b1; tick(); abort_i = 1'b0;
    check("idle_abort_busy", 32'(busy_o), 32'd0);
    check("idle_abort_code", 32'(start_dat_o), 32'd0);
    tick();
    check("idle_abort_code2", 32'(start_dat_o), 32'd0);

    // rst during RD_DATA of the second block
    s_ab = n_ab;
    begin_xfr(1'b1, 16'd1);
    wait_code("rst", 2'b10);
    tick();
    strobes(BLK, 8'h77);
    wait_code("rst2", 2'b10);
    tick();
    strobes(20, 8'h77);
    check("rst_pre_blks", 32'(blks_done_o), 32'd1);
    rst = 1'b1;
    tick();
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    tick(); tick();
    check("rst_no_abort", n_ab - s_ab, 32'd0);
    check("rst_idle_busy", 32'(busy_o), 32'd0);

    check("no_held_code", n_held, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
